// File: rtl/alu_sequencer.sv
// alu_sequencer: multicycle fetch/decode/execute/writeback controller that turns an 8-bit ALU into a small CPU core.
// Define CPU_STEP_EN to add a step input that holds FETCH until step is sampled high (one instruction per pulse).
module alu_sequencer #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
`ifdef CPU_STEP_EN
   input  logic              step,
`endif
   output logic [ADDR_W-1:0] instr_addr,
   input  logic [15:0]       instr_data,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [2:0]        alu_opcode,
   output logic              alu_save,
   input  logic [7:0]        alu_out,
   input  logic              carry_out,
   input  logic [1:0]        dbg_sel,
   output logic [7:0]        dbg_data,
   output logic              zero_flag,
   output logic              carry_flag,
   output logic              busy,
   output logic              done
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, DONE} state_t;
   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_inc, target;
   logic [3:0][7:0]   rf;
   logic [1:0]        rd_q, rd, rs;
   logic [3:0]        op4;
   logic [7:0]        imm;
   logic              fetch_go;
   assign op4        = instr_data[15:12];
   assign rd         = instr_data[11:10];
   assign rs         = instr_data[9:8];
   assign imm        = instr_data[7:0];
   assign pc_inc     = pc + ADDR_W'(1);
   assign target     = ADDR_W'(imm);
   // pc is the registered ROM address; a synchronous ROM returns the word during DECODE
   assign instr_addr = pc;
   assign dbg_data   = rf[dbg_sel];
`ifdef CPU_STEP_EN
   assign fetch_go   = step;
`else
   assign fetch_go   = 1'b1;
`endif
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   // next-state decode and per-state strobes
   always_comb begin
      state_n  = state;
      alu_save = 1'b0;
      done     = 1'b0;
      busy     = state != IDLE;
      case (state)
         IDLE:      state_n = start ? FETCH : IDLE;
         FETCH:     state_n = fetch_go ? DECODE : FETCH;
         DECODE:    state_n = !op4[3] ? EXECUTE : (op4 == 4'hF) ? DONE : FETCH;
         EXECUTE:   state_n = WRITEBACK;
         WRITEBACK: begin
            state_n  = FETCH;
            alu_save = 1'b1;
         end
         DONE:      begin
            state_n = IDLE;
            done    = 1'b1;
         end
         default:   state_n = IDLE;
      endcase
   end
   // datapath: pc, register file, ALU operand latches and flags
   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= '0;
         rf         <= '0;
         rd_q       <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) pc <= '0;
            DECODE: begin
               rd_q <= rd;
               if (!op4[3]) begin
                  alu_a      <= rf[rd];
                  alu_b      <= rf[rs];
                  alu_opcode <= op4[2:0];
               end else if (op4 == 4'h8) begin
                  rf[rd] <= imm;
                  pc     <= pc_inc;
               end else if (op4 == 4'h9) pc <= target;
               else if (op4 == 4'hA) pc <= zero_flag ? target : pc_inc;
               else if (op4 != 4'hF) pc <= pc_inc;
            end
            WRITEBACK: begin
               pc         <= pc_inc;
               zero_flag  <= alu_out == 8'h00;
               carry_flag <= carry_out;
               if (alu_opcode != 3'b111) rf[rd_q] <= alu_out;
            end
            default: ;
         endcase
      end
   end
endmodule
